// File: rtl/pipe_hazard_stall_ctrl.sv
// Stall/flush controller: counts outstanding cache requests per channel, freezes mapped
// pipeline stages while busy and defers flushes to frozen stages. Option: STALL_PERF_EN.
module pipe_hazard_stall_ctrl #(
   parameter int                          N_CH       = 2,
   parameter int                          NUM_STAGES = 3,
   parameter int                          MAX_OUT    = 2,
   parameter logic [N_CH*NUM_STAGES-1:0] STALL_MASK = 6'b111_001
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         ch_valid,
   input  logic [N_CH-1:0]         ch_ready,
   output logic [N_CH-1:0]         ch_accept,
   input  logic [NUM_STAGES-1:0]   flush_req,
   output logic [NUM_STAGES-1:0]   stall_o,
   output logic [NUM_STAGES-1:0]   flush_o,
   output logic                    pc_stall,
   output logic [N_CH-1:0]         err_o,
   input  logic                    perf_clr,
   output logic [N_CH*32-1:0]      perf_stall_cnt
);

   localparam int            CW      = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

   logic [CW-1:0]         cnt_q [N_CH];
   logic [CW-1:0]         cnt_d [N_CH];
   logic [N_CH-1:0]       fire, rsp, busy;
   logic [N_CH-1:0]       err_q, err_d;
   logic [NUM_STAGES-1:0] pend_q, pend_d;

   always_comb begin
      // NOTE: every combinational output gets a default before any loop or branch so no latch is inferred.
      fire      = '0;
      rsp       = '0;
      busy      = '0;
      ch_accept = '0;
      stall_o   = '0;
      for (int i = 0; i < N_CH; i++) begin
         ch_accept[i] = (cnt_q[i] != CNT_MAX);
         fire[i]      = ch_valid[i] & ch_accept[i];
         // A response counts only if something is (or just became) outstanding.
         rsp[i]       = ch_ready[i] & ((cnt_q[i] != '0) | fire[i]);
         cnt_d[i]     = cnt_q[i] + CW'(fire[i]) - CW'(rsp[i]);
         busy[i]      = (cnt_d[i] != '0);
         for (int s = 0; s < NUM_STAGES; s++) begin
            stall_o[s] = stall_o[s] | (busy[i] & STALL_MASK[i*NUM_STAGES+s]);
         end
      end
      pc_stall = |busy;
      err_d    = err_q | (ch_ready & ~rsp);
      flush_o  = (flush_req | pend_q) & ~stall_o;
      pend_d   = (flush_req | pend_q) & stall_o;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
         err_q  <= '0;
         pend_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
         err_q  <= err_d;
         pend_q <= pend_d;
      end
   end

   assign err_o = err_q;

`ifdef STALL_PERF_EN
   logic [31:0] perf_q [N_CH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_CH; i++) perf_q[i] <= '0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (perf_clr)
               perf_q[i] <= '0;
            else if (busy[i] && (perf_q[i] != 32'hFFFF_FFFF))
               perf_q[i] <= perf_q[i] + 32'd1;
         end
      end
   end

   always_comb begin
      perf_stall_cnt = '0;
      for (int i = 0; i < N_CH; i++) perf_stall_cnt[i*32 +: 32] = perf_q[i];
   end
`else
   // Counters are compiled out; the ports stay so the interface does not change.
   logic unused_perf_clr;
   assign unused_perf_clr = perf_clr;
   assign perf_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_stall_ctrl.sv
// Scoreboard bench for pipe_hazard_stall_ctrl: each step pushes its expected outputs,
// which are popped and compared once the combinational outputs settle.
module tb_pipe_hazard_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ch_valid, ch_ready, ch_accept, err_o;
   logic [2:0]  flush_req, stall_o, flush_o;
   logic        pc_stall, perf_clr;
   logic [63:0] perf_stall_cnt;

   int checks = 0;
   int errors = 0;

`ifdef STALL_PERF_EN
   localparam logic [31:0] PERF7 = 32'd7;
`else
   localparam logic [31:0] PERF7 = 32'd0;
`endif

   typedef struct packed {
      logic [2:0] stall;
      logic [2:0] flush;
      logic       pc;
      logic [1:0] acc;
      logic [1:0] err;
   } obs_t;

   typedef struct packed {
      logic [1:0]  v;
      logic [1:0]  r;
      logic [2:0]  f;
      logic        pclr;
      obs_t        e;
      logic        chk_perf;
      logic [31:0] p1;
      logic [31:0] p0;
   } step_t;

   step_t sb [$];

   pipe_hazard_stall_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .ch_valid       (ch_valid),
      .ch_ready       (ch_ready),
      .ch_accept      (ch_accept),
      .flush_req      (flush_req),
      .stall_o        (stall_o),
      .flush_o        (flush_o),
      .pc_stall       (pc_stall),
      .err_o          (err_o),
      .perf_clr       (perf_clr),
      .perf_stall_cnt (perf_stall_cnt)
   );

   always #5 clk = ~clk;

   function automatic obs_t observe();
      return '{stall: stall_o, flush: flush_o, pc: pc_stall, acc: ch_accept, err: err_o};
   endfunction

   function automatic step_t st(input logic [1:0] v, input logic [1:0] r, input logic [2:0] f,
                                input logic [2:0] stl, input logic [2:0] fl, input logic pc,
                                input logic [1:0] acc, input logic [1:0] err);
      step_t s;
      s = '0;
      s.v = v; s.r = r; s.f = f;
      s.e = '{stall: stl, flush: fl, pc: pc, acc: acc, err: err};
      return s;
   endfunction

   task automatic drive_push(input step_t s);
      ch_valid  = s.v;
      ch_ready  = s.r;
      flush_req = s.f;
      perf_clr  = s.pclr;
      sb.push_back(s);
   endtask

   task automatic test_reset();
      step_t exp;
      rst = 1'b0;
      drive_push(st(2'b00, 2'b00, 3'b011, 3'b000, 3'b011, 1'b0, 2'b11, 2'b00));
      #3;
      exp = sb.pop_front();
      checks++;
      if (observe() !== exp.e) begin
         errors++;
         $display("FAIL reset_hold: got %b want %b", observe(), exp.e);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      exp = st(2'b00, 2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00);
      exp.chk_perf = 1'b1;
      drive_push(exp);
      #2;
      exp = sb.pop_front();
      checks++;
      if (observe() !== exp.e) begin
         errors++;
         $display("FAIL reset_idle: got %b want %b", observe(), exp.e);
      end
      checks++;
      if (perf_stall_cnt !== {exp.p1, exp.p0}) begin
         errors++;
         $display("FAIL reset_perf: got %h want %h", perf_stall_cnt, {exp.p1, exp.p0});
      end
   endtask

   task automatic test_single();
      step_t tbl [$];
      step_t exp;
      tbl.push_back(st(2'b01, 2'b00, 3'b000, 3'b001, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b001, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b001, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b01, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00));
      tbl.push_back(st(2'b10, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b10, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00));
      foreach (tbl[k]) begin
         @(negedge clk);
         drive_push(tbl[k]);
         #2;
         exp = sb.pop_front();
         checks++;
         if (observe() !== exp.e) begin
            errors++;
            $display("FAIL single step %0d: got %b want %b", k, observe(), exp.e);
         end
      end
   endtask

   task automatic test_back_to_back();
      step_t tbl [$];
      step_t exp;
      tbl.push_back(st(2'b10, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b10, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b10, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b01, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b01, 2'b00));
      tbl.push_back(st(2'b00, 2'b10, 3'b000, 3'b111, 3'b000, 1'b1, 2'b01, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b10, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00));
      foreach (tbl[k]) begin
         @(negedge clk);
         drive_push(tbl[k]);
         #2;
         exp = sb.pop_front();
         checks++;
         if (observe() !== exp.e) begin
            errors++;
            $display("FAIL back_to_back step %0d: got %b want %b", k, observe(), exp.e);
         end
      end
   endtask

   task automatic test_flush_defer();
      step_t tbl [$];
      step_t exp;
      tbl.push_back(st(2'b10, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b010, 3'b111, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b100, 3'b111, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b10, 3'b000, 3'b000, 3'b110, 1'b0, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b001, 3'b000, 3'b001, 1'b0, 2'b11, 2'b00));
      // Only stage 0 is frozen by ch0: stage 1 flushes now, stage 0 waits.
      tbl.push_back(st(2'b01, 2'b00, 3'b011, 3'b001, 3'b010, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b01, 3'b000, 3'b000, 3'b001, 1'b0, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00));
      foreach (tbl[k]) begin
         @(negedge clk);
         drive_push(tbl[k]);
         #2;
         exp = sb.pop_front();
         checks++;
         if (observe() !== exp.e) begin
            errors++;
            $display("FAIL flush_defer step %0d: got %b want %b", k, observe(), exp.e);
         end
      end
   endtask

   task automatic test_perf();
      step_t tbl [$];
      step_t s;
      step_t exp;
      s = st(2'b00, 2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00);
      s.pclr = 1'b1;
      tbl.push_back(s);
      s = st(2'b00, 2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00);
      s.chk_perf = 1'b1;
      tbl.push_back(s);
      tbl.push_back(st(2'b10, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b11, 2'b00));
      for (int n = 0; n < 6; n++)
         tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b10, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00));
      s = st(2'b00, 2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00);
      s.pclr = 1'b1; s.chk_perf = 1'b1; s.p1 = PERF7;
      tbl.push_back(s);
      s = st(2'b00, 2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00);
      s.chk_perf = 1'b1;
      tbl.push_back(s);
      foreach (tbl[k]) begin
         @(negedge clk);
         drive_push(tbl[k]);
         #2;
         exp = sb.pop_front();
         checks++;
         if (observe() !== exp.e) begin
            errors++;
            $display("FAIL perf step %0d: got %b want %b", k, observe(), exp.e);
         end
         if (exp.chk_perf) begin
            checks++;
            if (perf_stall_cnt !== {exp.p1, exp.p0}) begin
               errors++;
               $display("FAIL perf_cnt step %0d: got %h want %h", k, perf_stall_cnt, {exp.p1, exp.p0});
            end
         end
      end
   endtask

   task automatic test_error();
      step_t tbl [$];
      step_t exp;
      tbl.push_back(st(2'b00, 2'b01, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b01));
      tbl.push_back(st(2'b01, 2'b01, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b01));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b01));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b01));
      foreach (tbl[k]) begin
         @(negedge clk);
         drive_push(tbl[k]);
         #2;
         exp = sb.pop_front();
         checks++;
         if (observe() !== exp.e) begin
            errors++;
            $display("FAIL error step %0d: got %b want %b", k, observe(), exp.e);
         end
      end
   endtask

   task automatic test_reset_mid();
      step_t tbl [$];
      step_t exp;
      tbl.push_back(st(2'b10, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b11, 2'b01));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b111, 3'b000, 1'b1, 2'b11, 2'b01));
      foreach (tbl[k]) begin
         @(negedge clk);
         drive_push(tbl[k]);
         #2;
         exp = sb.pop_front();
         checks++;
         if (observe() !== exp.e) begin
            errors++;
            $display("FAIL reset_mid pre step %0d: got %b want %b", k, observe(), exp.e);
         end
      end
      @(negedge clk);
      exp = st(2'b00, 2'b00, 3'b101, 3'b000, 3'b101, 1'b0, 2'b11, 2'b00);
      exp.chk_perf = 1'b1;
      drive_push(exp);
      #1 rst = 1'b0;
      #1;
      exp = sb.pop_front();
      checks++;
      if (observe() !== exp.e) begin
         errors++;
         $display("FAIL reset_mid async: got %b want %b", observe(), exp.e);
      end
      checks++;
      if (perf_stall_cnt !== {exp.p1, exp.p0}) begin
         errors++;
         $display("FAIL reset_mid perf: got %h want %h", perf_stall_cnt, {exp.p1, exp.p0});
      end
      @(negedge clk);
      rst = 1'b1;
      tbl.delete();
      tbl.push_back(st(2'b00, 2'b10, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b00));
      tbl.push_back(st(2'b00, 2'b00, 3'b000, 3'b000, 3'b000, 1'b0, 2'b11, 2'b10));
      foreach (tbl[k]) begin
         @(negedge clk);
         drive_push(tbl[k]);
         #2;
         exp = sb.pop_front();
         checks++;
         if (observe() !== exp.e) begin
            errors++;
            $display("FAIL reset_mid post step %0d: got %b want %b", k, observe(), exp.e);
         end
      end
   endtask

   initial begin
      ch_valid  = '0;
      ch_ready  = '0;
      flush_req = '0;
      perf_clr  = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_flush_defer();
      test_perf();
      test_error();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_stall_ctrl.md
Name: pipe_hazard_stall_ctrl

Overview:
- Parametrised front-end stall/flush controller driven by cache request/response handshakes.
- Tracks outstanding requests per cache channel (I-cache, D-cache, and future channels).
- Freezes a configurable subset of pipeline stages while any mapped channel is busy.
- Defers flushes aimed at frozen stages until those stages are released. Sits between the caches and the IF0/IF1/ID pipeline registers and the PC register.

Parameters:
N_CH, 2, number of cache channels
NUM_STAGES, 3, number of pipeline stage registers controlled (bit 0 = PC/IF0 side)
MAX_OUT, 2, maximum outstanding requests per channel (>=1)
STALL_MASK, 6'b111_001, packed N_CH*NUM_STAGES map; bit [i*NUM_STAGES+s] set = channel i busy stalls stage s

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
ch_valid  in  N_CH  request issued by channel i this cycle
ch_ready  in  N_CH  response/data returned by channel i this cycle
ch_accept  out  N_CH  channel i may issue (outstanding count below MAX_OUT)
flush_req  in  NUM_STAGES  flush request per stage
stall_o  out  NUM_STAGES  hold stage s register
flush_o  out  NUM_STAGES  clear stage s register
pc_stall  out  1  any channel busy
err_o  out  N_CH  sticky: response with nothing outstanding
perf_clr  in  1  clear perf counters (STALL_PERF_EN only)
perf_stall_cnt  out  N_CH*32  per-channel busy-cycle counters (STALL_PERF_EN only)

Behaviour:
- Reset (rst=0, async): cnt[i]=0, pend=0, err_o=0, perf counters=0. Resulting outputs: stall_o=0, flush_o=flush_req, pc_stall=0, ch_accept=all 1.
- cnt[i] width = clog2(MAX_OUT+1).
- fire[i] = ch_valid[i] & ch_accept[i].
- ch_accept[i] = (cnt[i] != MAX_OUT). ch_valid while not accepted is ignored and does not count.
- rsp[i] = ch_ready[i] & (cnt[i]!=0 | fire[i]).
  - ch_ready with cnt=0 and no fire sets err_o[i] on the next edge.
  - err_o[i] is sticky until reset.
- cnt_next[i] = cnt[i] + fire[i] - rsp[i]. Registered on each rising edge.
  - Simultaneous fire and rsp leaves cnt unchanged.
  - Never wraps: full blocks fire; empty blocks decrement.
- busy[i] = (cnt_next[i] != 0), combinational.
  - Stall asserts in the same cycle a request fires, unless it completes that cycle.
  - Stall drops in the same cycle the last response arrives.
- stall_o[s] = OR over i of (busy[i] & STALL_MASK[i*NUM_STAGES+s]).
- pc_stall = OR over busy[i].
- Flush deferral per stage s:
  - flush_o[s] = (flush_req[s] | pend[s]) & ~stall_o[s].
  - pend[s] <= (flush_req[s] | pend[s]) & stall_o[s].
  - Stall and flush in the same cycle on the same stage: stall wins and the flush is latched.
  - Repeated deferred flushes merge into one pulse.
  - The flush pulse is emitted in the first unstalled cycle, lasts exactly 1 cycle, then pend clears.
- Reset mid-operation clears everything. In-flight responses arriving after reset set err_o.
- All data outputs except err_o and perf are combinational from state and inputs. There is no extra latency.

Optional Feature:
- Macro: STALL_PERF_EN.
- Defined:
  - perf_stall_cnt[i*32+:32] increments on every cycle busy[i]=1.
  - Counters saturate at 32'hFFFF_FFFF.
  - perf_clr=1 synchronously zeroes all counters, with priority over increment.
- Undefined:
  - Counter logic is absent, perf_stall_cnt is tied to 0, and perf_clr is ignored.
  - Ports remain present so the interface is stable.

Test Plan:
- Defaults. Reset release, idle -> stall_o=3'b000, pc_stall=0, ch_accept=2'b11, err_o=0.
- ch_valid[0]=1 at cycle 0, ch_ready[0]=1 at cycle 3:
  - stall_o=3'b001 for cycles 0-2 and 0 at cycle 3.
  - Repeat on ch1 -> stall_o=3'b111 for cycles 0-2.
- ch1 two back-to-back fires -> cnt=2 and ch_accept[1]=0 on cycle 2; a third ch_valid is ignored. One ready -> cnt=1, stall held. Second ready -> stall released.
- ch1 busy, flush_req=3'b010 at cycle 1 and 3'b100 at cycle 2, release at cycle 5 -> flush_o=0 during cycles 1-4, flush_o=3'b110 for exactly cycle 5, 0 at cycle 6.
- ch_ready[0]=1 with cnt=0 -> err_o[0]=1 next cycle and stays 1. A same-cycle fire+ready on ch0 -> no stall, no error, cnt stays 0.
- STALL_PERF_EN: ch1 busy 7 cycles -> perf_stall_cnt[63:32]=7, [31:0]=0. perf_clr -> both 0 next cycle. Async reset asserted mid-stall -> stall_o=0 immediately and cnt=0.
